dino_jump_ctrl: RTL and testbench

//  Per-frame vertical motion controller for the dinosaur sprite. Sits upstream of the bitmap

---
 rtl/dino_jump_ctrl.sv | 139 +++++++++++++
 tb/tb_dino_jump_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// Per-frame jump physics for the dinosaur sprite: samples the raster once per frame in
// vertical blanking and drives the sprite bounding box used by the renderer.
//
// state  | meaning
// GROUND | standing at GROUND_Y, waiting for a jump request
// RISE   | moving up, velocity decays by GRAVITY each frame
// FALL   | moving down, velocity grows to MAX_FALL, lands at GROUND_Y
module dino_jump_ctrl #(
  parameter int SPRITE_LEFT = 300,
  parameter int SPRITE_W    = 20,
  parameter int SPRITE_H    = 16,
  parameter int GROUND_Y    = 200,
  parameter int TOP_LIMIT   = 40,
  parameter int JUMP_V      = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 15,
  parameter int FRAME_H     = 0,
  parameter int FRAME_V     = 481
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        jump_btn,
  input  logic        freeze,
  output logic [10:0] sprite_left,
  output logic [10:0] sprite_right,
  output logic [10:0] sprite_top,
  output logic [10:0] sprite_bottom,
  output logic        airborne,
  output logic        land_pulse,
  output logic        frame_tick
);

  typedef enum logic [1:0] {S_GROUND, S_RISE, S_FALL} state_t;

  localparam logic [11:0] C_GROUND12 = 12'(GROUND_Y);
  localparam logic [10:0] C_GROUND11 = 11'(GROUND_Y);
  localparam logic [11:0] C_LIMIT12  = 12'(TOP_LIMIT);
  localparam logic [10:0] C_LIMIT11  = 11'(TOP_LIMIT);
  localparam logic [11:0] C_GRAV12   = 12'(GRAVITY);
  localparam logic [4:0]  C_GRAV5    = 5'(GRAVITY);
  localparam logic [10:0] C_JTOP     = 11'(GROUND_Y - JUMP_V);
  localparam logic [4:0]  C_JVEL     = 5'(JUMP_V - GRAVITY);

  state_t      r_state;
  logic [10:0] r_top;
  logic [4:0]  r_vel;
  logic        r_sync1, r_sync2, r_sync3;
  logic        r_pending;
  logic        r_tick;
  logic        r_land;

  logic        w_match;
  logic        w_edge;
  logic [11:0] w_top;
  logic [11:0] w_vel;
  logic [5:0]  w_vel_inc;
  logic [4:0]  w_fall_v;
  logic [10:0] w_vel11;

  assign w_match   = (hcount == 11'(FRAME_H)) && (vcount == 11'(FRAME_V));
  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_top     = {1'b0, r_top};
  assign w_vel     = {7'd0, r_vel};
  assign w_vel11   = {6'd0, r_vel};
  assign w_vel_inc = {1'b0, r_vel} + 6'(GRAVITY);
  assign w_fall_v  = (w_vel_inc > 6'(MAX_FALL)) ? 5'(MAX_FALL) : w_vel_inc[4:0];

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_GROUND;
      r_top     <= C_GROUND11;
      r_vel     <= 5'd0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_land    <= 1'b0;
    end else begin
      r_sync1 <= jump_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= w_match;
      r_land  <= 1'b0;
      // every tick consumes or drops the request; an edge landing on the tick survives
      if (r_tick) r_pending <= w_edge;
      else if (w_edge) r_pending <= 1'b1;
      if (r_tick && !freeze) begin
        case (r_state)
          S_GROUND: begin
            if (r_pending) begin
              r_top   <= C_JTOP;
              r_vel   <= C_JVEL;
              r_state <= S_RISE;
            end
          end
          S_RISE: begin
            if (w_top < w_vel + C_LIMIT12) begin
              r_top   <= C_LIMIT11;
              r_vel   <= 5'd0;
              r_state <= S_FALL;
            end else begin
              r_top <= r_top - w_vel11;
              if (w_vel <= C_GRAV12) begin
                r_vel   <= 5'd0;
                r_state <= S_FALL;
              end else begin
                r_vel <= r_vel - C_GRAV5;
              end
            end
          end
          S_FALL: begin
            if (w_top + w_vel >= C_GROUND12) begin
              r_top   <= C_GROUND11;
              r_vel   <= 5'd0;
              r_state <= S_GROUND;
              r_land  <= 1'b1;
            end else begin
              r_top <= r_top + w_vel11;
              r_vel <= w_fall_v;
            end
          end
          default: r_state <= S_GROUND;
        endcase
      end
    end
  end

  assign sprite_left   = 11'(SPRITE_LEFT);
  assign sprite_right  = 11'(SPRITE_LEFT + SPRITE_W);
  assign sprite_top    = r_top;
  assign sprite_bottom = r_top + 11'(SPRITE_H);
  assign airborne      = (r_state != S_GROUND);
  assign land_pulse    = r_land;
  assign frame_tick    = r_tick;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: shortened raster (10 px x 10 lines around the update line),
// expected per-frame sprite positions queued at stimulus time and popped after each update.
module tb_dino_jump_ctrl;

  logic        clk_25 = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [10:0] vcount = 11'd476;
  logic        jump_btn = 1'b0, jump_btn2 = 1'b0, freeze = 1'b0, freeze2 = 1'b0;
  logic [10:0] s_left, s_right, s_top, s_bot;
  logic [10:0] s2_left, s2_right, s2_top, s2_bot;
  logic        air, land, tick, air2, land2, tick2;
  logic        m_tick, m_upd;

  int errors = 0;
  int checks = 0;

  typedef struct {int top; bit air; bit land;} exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int traj_def[25] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123, 122,
                       122, 123, 125, 128, 132, 137, 143, 150, 158, 167, 177, 188, 200};
  int traj_big[19] = '{180, 161, 143, 126, 120,
                       120, 121, 123, 126, 130, 135, 141, 148, 156, 165, 175, 186, 198, 200};

  dino_jump_ctrl dut (
    .clk_25(clk_25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .jump_btn(jump_btn), .freeze(freeze),
    .sprite_left(s_left), .sprite_right(s_right), .sprite_top(s_top), .sprite_bottom(s_bot),
    .airborne(air), .land_pulse(land), .frame_tick(tick)
  );

  dino_jump_ctrl #(.JUMP_V(20), .TOP_LIMIT(120)) dut2 (
    .clk_25(clk_25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .jump_btn(jump_btn2), .freeze(freeze2),
    .sprite_left(s2_left), .sprite_right(s2_right), .sprite_top(s2_top), .sprite_bottom(s2_bot),
    .airborne(air2), .land_pulse(land2), .frame_tick(tick2)
  );

  always #20 clk_25 = ~clk_25;

  always @(posedge clk_25) begin
    if (hcount == 11'd9) begin
      hcount <= 11'd0;
      vcount <= (vcount == 11'd485) ? 11'd476 : vcount + 11'd1;
    end else begin
      hcount <= hcount + 11'd1;
    end
  end

  // reference timing: tick one cycle after the raster match, update visible the cycle after
  always @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      m_tick <= 1'b0;
      m_upd  <= 1'b0;
    end else begin
      m_tick <= (hcount == 11'd0) && (vcount == 11'd481);
      m_upd  <= m_tick;
    end
  end

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_25);
      if (rst_n) begin
        checks += 2;
        if (tick !== m_tick) begin errors++; $display("FAIL frame_tick: got %b want %b at %0t", tick, m_tick, $time); end
        if (tick2 !== m_tick) begin errors++; $display("FAIL frame_tick2: got %b want %b at %0t", tick2, m_tick, $time); end
        if (m_upd) begin
          if (q1.size() > 0) begin
            e = q1.pop_front();
            checks += 4;
            if (s_top !== 11'(e.top)) begin errors++; $display("FAIL top: got %0d want %0d at %0t", s_top, e.top, $time); end
            if (s_bot !== 11'(e.top + 16)) begin errors++; $display("FAIL bottom: got %0d want %0d", s_bot, e.top + 16); end
            if (air !== e.air) begin errors++; $display("FAIL airborne: got %b want %b at %0t", air, e.air, $time); end
            if (land !== e.land) begin errors++; $display("FAIL land_pulse: got %b want %b at %0t", land, e.land, $time); end
          end
          if (q2.size() > 0) begin
            e = q2.pop_front();
            checks += 4;
            if (s2_top !== 11'(e.top)) begin errors++; $display("FAIL top2: got %0d want %0d at %0t", s2_top, e.top, $time); end
            if (s2_bot !== 11'(e.top + 16)) begin errors++; $display("FAIL bottom2: got %0d want %0d", s2_bot, e.top + 16); end
            if (air2 !== e.air) begin errors++; $display("FAIL airborne2: got %b want %b", air2, e.air); end
            if (land2 !== e.land) begin errors++; $display("FAIL land_pulse2: got %b want %b", land2, e.land); end
          end
        end else begin
          checks += 2;
          if (land !== 1'b0) begin errors++; $display("FAIL land_idle: got %b want 0 at %0t", land, $time); end
          if (land2 !== 1'b0) begin errors++; $display("FAIL land_idle2: got %b want 0 at %0t", land2, $time); end
        end
      end
    end
  endtask

  task automatic wait_upd(input int n);
    int seen = 0;
    int budget = n * 150 + 50;
    while (seen < n && budget > 0) begin
      @(negedge clk_25);
      budget--;
      if (m_upd) seen++;
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL wait_upd: got %0d updates want %0d", seen, n);
    end
    @(posedge clk_25);
  endtask

  task automatic press(input bit second);
    @(negedge clk_25);
    if (second) jump_btn2 = 1'b1; else jump_btn = 1'b1;
    repeat (5) @(negedge clk_25);
    jump_btn = 1'b0;
    jump_btn2 = 1'b0;
  endtask

  task automatic push_def(input int from, input int to);
    for (int i = from; i <= to; i++) q1.push_back('{traj_def[i], (i != 24), (i == 24)});
  endtask

  task automatic push_ground(input int n);
    for (int i = 0; i < n; i++) q1.push_back('{200, 1'b0, 1'b0});
  endtask

  task automatic wait_raster(input int h, input int v);
    int budget = 300;
    @(negedge clk_25);
    while (!(hcount == 11'(h) && vcount == 11'(v)) && budget > 0) begin
      @(negedge clk_25);
      budget--;
    end
    if (budget == 0) begin checks++; errors++; $display("FAIL wait_raster: position %0d,%0d not seen", h, v); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_25);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    end
    checks += 7;
    if (s_top !== 11'd200) begin errors++; $display("FAIL reset_top: got %0d want 200", s_top); end
    if (s_bot !== 11'd216) begin errors++; $display("FAIL reset_bottom: got %0d want 216", s_bot); end
    if (s_left !== 11'd300) begin errors++; $display("FAIL reset_left: got %0d want 300", s_left); end
    if (s_right !== 11'd320) begin errors++; $display("FAIL reset_right: got %0d want 320", s_right); end
    if (air !== 1'b0) begin errors++; $display("FAIL reset_air: got %b want 0", air); end
    if (land !== 1'b0) begin errors++; $display("FAIL reset_land: got %b want 0", land); end
    if (s2_top !== 11'd200) begin errors++; $display("FAIL reset_top2: got %0d want 200", s2_top); end
    rst_n = 1'b1;
    wait_upd(1);
  endtask

  task automatic test_single_jump();
    push_def(0, 24);
    push_ground(2);
    press(1'b0);
    wait_upd(27);
  endtask

  task automatic test_no_double_jump();
    push_def(0, 24);
    push_ground(2);
    press(1'b0);
    wait_upd(5);
    press(1'b0);
    wait_upd(22);
  endtask

  task automatic test_coincident_press();
    push_ground(1);
    push_def(0, 24);
    wait_raster(9, 480);
    jump_btn = 1'b1;
    repeat (2) @(negedge clk_25);
    jump_btn = 1'b0;
    wait_upd(26);
    // one cycle earlier the request is already pending at the tick
    push_def(0, 24);
    wait_raster(8, 480);
    jump_btn = 1'b1;
    repeat (2) @(negedge clk_25);
    jump_btn = 1'b0;
    wait_upd(25);
  endtask

  task automatic test_ceiling_clamp();
    for (int i = 0; i < 19; i++) q2.push_back('{traj_big[i], (i != 18), (i == 18)});
    q2.push_back('{200, 1'b0, 1'b0});
    press(1'b1);
    wait_upd(20);
  endtask

  task automatic test_freeze_and_reset();
    push_def(0, 4);
    press(1'b0);
    wait_upd(5);
    @(negedge clk_25);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) q1.push_back('{150, 1'b1, 1'b0});
    wait_upd(10);
    @(negedge clk_25);
    freeze = 1'b0;
    push_def(5, 9);
    wait_upd(5);
    @(negedge clk_25);
    #5 rst_n = 1'b0;
    #1;
    checks += 4;
    if (s_top !== 11'd200) begin errors++; $display("FAIL midair_reset_top: got %0d want 200", s_top); end
    if (s_bot !== 11'd216) begin errors++; $display("FAIL midair_reset_bottom: got %0d want 216", s_bot); end
    if (air !== 1'b0) begin errors++; $display("FAIL midair_reset_air: got %b want 0", air); end
    if (land !== 1'b0) begin errors++; $display("FAIL midair_reset_land: got %b want 0", land); end
    q1.delete();
    repeat (3) @(negedge clk_25);
    rst_n = 1'b1;
    // a press while frozen on the ground is dropped, not deferred
    freeze = 1'b1;
    push_ground(1);
    press(1'b0);
    wait_upd(1);
    @(negedge clk_25);
    freeze = 1'b0;
    push_ground(2);
    wait_upd(2);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_jump();
    test_no_double_jump();
    test_coincident_press();
    test_ceiling_clamp();
    test_freeze_and_reset();
    checks++;
    if (q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", q1.size() + q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
